// File: rtl/mig_ws_bridge_if.sv
// Bus bundle between a Wishbone line master and the memory-controller app port.
// The bridge takes the master modport; the environment side takes slave.
interface mig_ws_bridge_if #(
    parameter int LINE_W = 512,
    parameter int APP_W  = 128,
    parameter int ADDR_W = 27
);
    logic [31:0]         ws_addr;
    logic [LINE_W-1:0]   ws_din;
    logic [LINE_W/8-1:0] ws_dm;
    logic                ws_cyc;
    logic                ws_stb;
    logic                ws_we;
    logic                ws_ack;
    logic [LINE_W-1:0]   ws_dout;

    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [APP_W-1:0]    app_wdf_data;
    logic [APP_W/8-1:0]  app_wdf_mask;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic                app_wdf_rdy;
    logic [APP_W-1:0]    app_rd_data;
    logic                app_rd_data_valid;

    modport master (
        input  ws_addr, ws_din, ws_dm, ws_cyc, ws_stb, ws_we,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output ws_ack, ws_dout,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output ws_addr, ws_din, ws_dm, ws_cyc, ws_stb, ws_we,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  ws_ack, ws_dout,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/mig_ws_bridge.sv
// Wishbone line slave to memory-controller app port bridge: one line per request,
// split into BEATS app-width data beats and commands.
module mig_ws_bridge #(
    parameter int LINE_W    = 512,
    parameter int APP_W     = 128,
    parameter int ADDR_W    = 27,
    parameter int ADDR_STEP = 8,
    parameter int POSTED_WR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            calib_done,
    mig_ws_bridge_if.master bus,
    output logic [2:0]      dbg_state
);
    localparam int BEATS   = LINE_W / APP_W;
    localparam int CNT_W   = $clog2(BEATS);
    localparam int MSK_W   = APP_W / 8;
    localparam int LINE_SH = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RD_CMD  = 3'b001,
        RD_WAIT = 3'b010,
        WR_DATA = 3'b011,
        WR_CMD  = 3'b100,
        ACK     = 3'b111
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wr_cnt_q, cmd_cnt_q, rd_cnt_q;
    logic                 rd_done_q;
    logic                 ws_ack_q;
    logic                 live_q;
    logic [LINE_W-1:0]    dout_q;
    logic [LINE_W-1:0]    din_q;
    logic [LINE_W/8-1:0]  dm_q;
    logic [31-LINE_SH:0]  line_q;

    logic cap, ack_set, req;
    logic app_en_c, wren_c;
    logic [2:0] app_cmd_c;
    logic wr_acc, cmd_acc, rd_stb, rd_last, rd_all;

    // live_q holds off acceptance until the second edge after reset release
    assign req     = bus.ws_cyc & bus.ws_stb & calib_done & live_q;
    assign wr_acc  = (state_q == WR_DATA) & bus.app_wdf_rdy;
    assign cmd_acc = ((state_q == WR_CMD) | (state_q == RD_CMD)) & bus.app_rdy;
    assign rd_stb  = bus.app_rd_data_valid & ~rd_done_q &
                     ((state_q == RD_CMD) | (state_q == RD_WAIT));
    assign rd_last = rd_stb & (rd_cnt_q == LAST);
    assign rd_all  = rd_done_q | rd_last;

    always_comb begin
        state_d   = state_q;
        cap       = 1'b0;
        ack_set   = 1'b0;
        app_en_c  = 1'b0;
        app_cmd_c = 3'b000;
        wren_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cap     = 1'b1;
                    state_d = bus.ws_we ? WR_DATA : RD_CMD;
                    ack_set = bus.ws_we & (POSTED_WR != 0);
                end
            end
            WR_DATA: begin
                wren_c = 1'b1;
                if (wr_acc && wr_cnt_q == LAST) state_d = WR_CMD;
            end
            WR_CMD: begin
                app_en_c = 1'b1;
                if (cmd_acc && cmd_cnt_q == LAST) begin
                    if (POSTED_WR != 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACK;
                        ack_set = 1'b1;
                    end
                end
            end
            RD_CMD: begin
                app_en_c  = 1'b1;
                app_cmd_c = 3'b001;
                // all data may already be in before the final command goes out
                if (cmd_acc && cmd_cnt_q == LAST) begin
                    state_d = rd_all ? ACK : RD_WAIT;
                    ack_set = rd_all;
                end
            end
            RD_WAIT: begin
                if (rd_all) begin
                    state_d = ACK;
                    ack_set = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ws_ack_q  <= 1'b0;
            wr_cnt_q  <= '0;
            cmd_cnt_q <= '0;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
            live_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q  <= state_d;
            ws_ack_q <= ack_set;
            live_q   <= 1'b1;
            if (cap) begin
                wr_cnt_q  <= '0;
                cmd_cnt_q <= '0;
                rd_cnt_q  <= '0;
                rd_done_q <= 1'b0;
            end else begin
                if (wr_acc)  wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
                if (cmd_acc) cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                if (rd_stb)  rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
                if (rd_last) rd_done_q <= 1'b1;
            end
            if (rd_stb) dout_q[rd_cnt_q*APP_W +: APP_W] <= bus.app_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            line_q <= bus.ws_addr[31:LINE_SH];
            din_q  <= bus.ws_din;
            dm_q   <= bus.ws_dm;
        end
    end

    // (line_index*BEATS + n)*ADDR_STEP, reduced modulo 2^ADDR_W
    assign bus.app_addr     = ADDR_W'({line_q, cmd_cnt_q}) * ADDR_W'(ADDR_STEP);
    assign bus.app_cmd      = app_cmd_c;
    assign bus.app_en       = app_en_c;
    assign bus.app_wdf_data = din_q[wr_cnt_q*APP_W +: APP_W];
    assign bus.app_wdf_mask = ~dm_q[wr_cnt_q*MSK_W +: MSK_W];
    assign bus.app_wdf_wren = wren_c;
    assign bus.app_wdf_end  = wren_c;
    assign bus.ws_ack       = ws_ack_q;
    assign bus.ws_dout      = dout_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_mig_ws_bridge.sv
// Directed bench for mig_ws_bridge: a posted-write instance and a non-posted
// instance share stimulus, with sel choosing which one sees requests.
module tb_mig_ws_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, calib_done, sel;
    logic [31:0]  ws_addr;
    logic [511:0] ws_din;
    logic [63:0]  ws_dm;
    logic         ws_cyc, ws_stb, ws_we;
    logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_rd_data;
    logic [2:0]   st_p, st_n;

    logic         o_ack, o_en, o_wren, o_end;
    logic [2:0]   o_cmd, o_state;
    logic [26:0]  o_addr;
    logic [127:0] o_wdata;
    logic [15:0]  o_mask;
    logic [511:0] o_dout;

    int n_chk = 0;
    int n_fail = 0;

    mig_ws_bridge_if #(.LINE_W(512), .APP_W(128), .ADDR_W(27)) ifp ();
    mig_ws_bridge_if #(.LINE_W(512), .APP_W(128), .ADDR_W(27)) ifn ();

    mig_ws_bridge #(.POSTED_WR(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .bus(ifp.master), .dbg_state(st_p));
    mig_ws_bridge #(.POSTED_WR(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .bus(ifn.master), .dbg_state(st_n));

    assign ifp.ws_addr = ws_addr;          assign ifn.ws_addr = ws_addr;
    assign ifp.ws_din  = ws_din;           assign ifn.ws_din  = ws_din;
    assign ifp.ws_dm   = ws_dm;            assign ifn.ws_dm   = ws_dm;
    assign ifp.ws_we   = ws_we;            assign ifn.ws_we   = ws_we;
    assign ifp.ws_cyc  = ws_cyc & ~sel;    assign ifn.ws_cyc  = ws_cyc & sel;
    assign ifp.ws_stb  = ws_stb & ~sel;    assign ifn.ws_stb  = ws_stb & sel;
    assign ifp.app_rdy = app_rdy;          assign ifn.app_rdy = app_rdy;
    assign ifp.app_wdf_rdy = app_wdf_rdy;  assign ifn.app_wdf_rdy = app_wdf_rdy;
    assign ifp.app_rd_data = app_rd_data;  assign ifn.app_rd_data = app_rd_data;
    assign ifp.app_rd_data_valid = app_rd_data_valid;
    assign ifn.app_rd_data_valid = app_rd_data_valid;

    assign o_ack   = sel ? ifn.ws_ack       : ifp.ws_ack;
    assign o_en    = sel ? ifn.app_en       : ifp.app_en;
    assign o_wren  = sel ? ifn.app_wdf_wren : ifp.app_wdf_wren;
    assign o_end   = sel ? ifn.app_wdf_end  : ifp.app_wdf_end;
    assign o_cmd   = sel ? ifn.app_cmd      : ifp.app_cmd;
    assign o_addr  = sel ? ifn.app_addr     : ifp.app_addr;
    assign o_wdata = sel ? ifn.app_wdf_data : ifp.app_wdf_data;
    assign o_mask  = sel ? ifn.app_wdf_mask : ifp.app_wdf_mask;
    assign o_dout  = sel ? ifn.ws_dout      : ifp.ws_dout;
    assign o_state = sel ? st_n             : st_p;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [511:0] din, input logic [63:0] dm,
                            input logic [26:0] base, input bit rnd, input int ack_exp);
        int nd, nc, nack, ack_it, nc_at_ack, post;
        bit overlap, order_bad, fin;
        logic [15:0] em;
        logic [26:0] ea;
        nd = 0; nc = 0; nack = 0; ack_it = -1; nc_at_ack = -1; post = 0;
        overlap = 0; order_bad = 0; fin = 0;
        ws_addr = addr; ws_din = din; ws_dm = dm; ws_we = 1'b1; ws_cyc = 1'b1; ws_stb = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int it = 0; it < 300 && !fin; it++) begin
            @(negedge clk);
            if (rnd) begin
                app_rdy     = 1'($urandom_range(0, 1));
                app_wdf_rdy = 1'($urandom_range(0, 1));
            end
            if (o_en && o_wren) overlap = 1;
            if (o_wren && app_wdf_rdy) begin
                em = ~dm[nd*16 +: 16];
                check("wr_data", o_wdata, din[nd*128 +: 128]);
                check("wr_mask", o_mask, em);
                check("wr_end", o_end, 1'b1);
                nd++;
            end
            if (o_en && app_rdy) begin
                ea = base + 27'(8 * nc);
                check("wr_cmd", o_cmd, 3'b000);
                check("wr_addr", o_addr, ea);
                if (nd != 4) order_bad = 1;
                nc++;
            end
            if (o_ack) begin
                nack++;
                if (ack_it < 0) begin
                    ack_it = it;
                    nc_at_ack = nc;
                    check("wr_ack_state", o_state, sel ? 3'b111 : 3'b011);
                end
                ws_cyc = 1'b0; ws_stb = 1'b0;
            end
            if (nc >= 4 && nack > 0 && o_state == 3'd0) begin
                post++;
                if (post == 4) fin = 1;
            end
        end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; ws_cyc = 1'b0; ws_stb = 1'b0;
        check("wr_finished", fin, 1'b1);
        check("wr_beats", nd, 4);
        check("wr_cmds", nc, 4);
        check("wr_acks", nack, 1);
        check("wr_overlap", overlap, 1'b0);
        check("wr_order", order_bad, 1'b0);
        check("wr_cmds_at_ack", nc_at_ack, sel ? 4 : 0);
        if (ack_exp >= 0) check("wr_ack_cycle", ack_it, ack_exp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [26:0] base, input int lat,
                           input logic [3:0] seed, input int ack_exp, input int abort_it,
                           input logic [511:0] exp_line);
        int due[4];
        int nc, nack, ack_it, post;
        bit aborted, fin;
        logic [26:0] ea;
        for (int k = 0; k < 4; k++) due[k] = -1;
        nc = 0; nack = 0; ack_it = -1; post = 0; aborted = 0; fin = 0;
        ws_addr = addr; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int it = 0; it < 100 && !fin; it++) begin
            @(negedge clk);
            app_rd_data_valid = 1'b0;
            app_rd_data = '0;
            if (aborted && it == abort_it + 1) rst_n = 1'b1;
            if (it == abort_it) begin
                rst_n = 1'b0;
                #1;
                check("abort_state", o_state, 3'd0);
                check("abort_ack", o_ack, 1'b0);
                check("abort_en", o_en, 1'b0);
                check("abort_dout", o_dout, '0);
                ws_cyc = 1'b0; ws_stb = 1'b0;
                aborted = 1;
            end
            if (o_en && o_wren) check("rd_overlap", 1'b1, 1'b0);
            if (o_en && app_rdy) begin
                ea = base + 27'(8 * nc);
                check("rd_cmd", o_cmd, 3'b001);
                check("rd_addr", o_addr, ea);
                if (nc < 4) due[nc] = it + lat;
                nc++;
            end
            for (int k = 0; k < 4; k++) begin
                if (due[k] == it) begin
                    app_rd_data_valid = 1'b1;
                    app_rd_data = {32{seed + 4'(k)}};
                end
            end
            if (o_ack) begin
                nack++;
                if (ack_it < 0) begin
                    ack_it = it;
                    check("rd_ack_state", o_state, 3'b111);
                end
                ws_cyc = 1'b0; ws_stb = 1'b0;
            end
            if (aborted) begin
                if (it >= abort_it + 4) fin = 1;
            end else if (nack > 0 && o_state == 3'd0) begin
                post++;
                if (post == 3) fin = 1;
            end
        end
        app_rd_data_valid = 1'b0;
        ws_cyc = 1'b0; ws_stb = 1'b0;
        check("rd_finished", fin, 1'b1);
        if (aborted) begin
            check("abort_no_ack", nack, 0);
            check("abort_late_beats", o_dout, '0);
            check("abort_idle", o_state, 3'd0);
        end else begin
            check("rd_cmds", nc, 4);
            check("rd_acks", nack, 1);
            check("rd_ack_cycle", ack_it, ack_exp);
            check("rd_line", o_dout, exp_line);
            check("rd_low_beat", o_dout[127:0], exp_line[127:0]);
            check("rd_high_beat", o_dout[511:384], exp_line[511:384]);
        end
    endtask

    logic [511:0] line_a, line_1, line_5, line_6, din1, din2, din3;

    initial begin
        line_a = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
        line_1 = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
        line_5 = {{32{4'h8}}, {32{4'h7}}, {32{4'h6}}, {32{4'h5}}};
        line_6 = {{32{4'h9}}, {32{4'h8}}, {32{4'h7}}, {32{4'h6}}};
        din1 = {{4{32'hD3D3_0003}}, {4{32'hC2C2_0002}}, {4{32'hB1B1_0001}}, {4{32'hA0A0_0000}}};
        din2 = {{8{16'h7E57}}, {8{16'h0F0F}}, {8{16'hFFFF}}, {8{16'h1357}}};
        din3 = {{4{32'hCAFE_F00D}}, {4{32'h0123_4567}}, {4{32'h89AB_CDEF}}, {4{32'hDEAD_BEEF}}};

        sel = 1'b0; rst_n = 1'b0; calib_done = 1'b1;
        ws_addr = '0; ws_din = '0; ws_dm = '0; ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_state", o_state, 3'd0);
        check("rst_state_np", st_n, 3'd0);
        check("rst_ack", o_ack, 1'b0);
        check("rst_en", o_en, 1'b0);
        check("rst_wren", o_wren, 1'b0);
        check("rst_dout", o_dout, '0);

        // request already pending at release: capture on the second edge
        rst_n = 1'b1;
        do_write(32'h40, din1, 64'hFFFF_FFFF_FFFF_FFFF, 27'h20, 1'b0, 1);
        check("wr_keeps_dout", o_dout, '0);
        do_write(32'h1000, din2, 64'h0, 27'h800, 1'b0, 0);

        do_read(32'h80, 27'h40, 3, 4'hA, 7, -1, line_a);
        @(negedge clk);
        app_rd_data_valid = 1'b1; app_rd_data = {32{4'h5}};
        repeat (2) @(negedge clk);
        app_rd_data_valid = 1'b0;
        check("idle_rd_ignored", o_dout, line_a);

        do_write(32'h7FFF_FFC0, din3, 64'h00FF_F0F0_0001_8000, 27'h7FF_FFE0, 1'b0, 0);
        check("dout_held", o_dout, line_a);

        do_read(32'h1C0, 27'hE0, 1, 4'h1, 5, -1, line_1);
        do_read(32'h0, 27'h0, 0, 4'h5, 4, -1, line_5);

        calib_done = 1'b0;
        ws_addr = 32'h40; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nocal_en", o_en, 1'b0);
            check("nocal_ack", o_ack, 1'b0);
            check("nocal_state", o_state, 3'd0);
        end
        calib_done = 1'b1;
        do_read(32'h40, 27'h20, 2, 4'h6, 6, -1, line_6);

        do_read(32'h80, 27'h40, 3, 4'h2, -1, 5, '0);
        do_read(32'h80, 27'h40, 3, 4'hA, 7, -1, line_a);

        sel = 1'b1;
        @(negedge clk);
        do_write(32'hC0, din1, 64'hFFFF_FFFF_FFFF_FFFF, 27'h60, 1'b0, 8);
        do_write(32'hC0, din3, 64'hF0F0_0000_FFFF_1234, 27'h60, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
